// File: rtl/kv10_io_pkg.sv
// kv10_io_pkg: shared types and condition-word layout for KV10 I/O bus devices
package kv10_io_pkg;
   typedef logic [35:0] word_t;
   typedef enum logic [2:0] {BLKI, DATAI, BLKO, DATAO, CONO, CONI, CONSZ, CONSO} ioop_t;
   typedef enum logic [2:0] {IDLE, EXEC, WAIT, ACK, RELEASE} state_t;
   // PDP-10 numbers bits from the MSB, so bit n lives at vector index 35-n
   localparam int B_DONE   = 35 - 32;
   localparam int B_BUSY   = 35 - 31;
   localparam int B_TXDONE = 35 - 30;
   localparam int B_UNDER  = 35 - 29;
   localparam int B_OVER   = 35 - 28;
   localparam int B_FLUSH  = 35 - 32;
   localparam int B_CLEAR  = 35 - 31;
   function automatic word_t cond_word(input logic [2:0] pia, input logic done, busy, txdone, under, over);
      word_t w;
      w = '0;
      w[2:0] = pia;
      w[B_DONE] = done;
      w[B_BUSY] = busy;
      w[B_TXDONE] = txdone;
      w[B_UNDER] = under;
      w[B_OVER] = over;
      return w;
   endfunction
endpackage

// File: rtl/io_responder_if.sv
// io_responder_if: CPU-side KV10 I/O bus, master = CPU decoder, slave = device responder
interface io_responder_if import kv10_io_pkg::*; ();
   logic       io_req;
   logic [6:0] io_dev;
   ioop_t      io_op;
   word_t      io_wdata;
   logic       io_ack;
   word_t      io_rdata;
   modport master (output io_req, io_dev, io_op, io_wdata, input io_ack, io_rdata);
   modport slave (input io_req, io_dev, io_op, io_wdata, output io_ack, io_rdata);
endinterface

// File: rtl/io_fifo.sv
// io_fifo: synchronous receive FIFO with flush and occupancy count
module io_fifo import kv10_io_pkg::*; #(
   parameter int DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  push,
   input  logic                  pop,
   input  word_t                 din,
   output word_t                 dout,
   output logic                  full,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   word_t mem [DEPTH];
   logic [AW-1:0] wr, rd;
   assign dout = mem[rd];
   assign full = count == (AW+1)'(DEPTH);
   always_ff @(posedge clk)
      if (push) mem[wr] <= din;
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr <= '0;
         rd <= '0;
         count <= '0;
      end else begin
         wr <= wr + AW'(push);
         rd <= rd + AW'(pop);
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end
endmodule

// File: rtl/io_responder.sv
// io_responder: KV10 I/O bus device responder (rx FIFO, tx register, CONO/CONI, PI request)
// Define IO_RESPONDER_TIMEOUT_EN to let stalled DATAI/DATAO wait up to TIMEOUT cycles.
module io_responder import kv10_io_pkg::*; #(
   parameter logic [6:0] DEV_NUM    = 7'o24,
   parameter int         FIFO_DEPTH = 4,
   parameter int         TIMEOUT    = 255
) (
   input  logic           clk,
   input  logic           reset,
   io_responder_if.slave  bus,
   input  logic           dev_in_valid,
   input  word_t          dev_in_data,
   output logic           dev_in_ready,
   output logic           dev_out_valid,
   output word_t          dev_out_data,
   input  logic           dev_out_ready,
   output logic [6:0]     pi_req
);
   if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
      $error("io_responder: unsupported FIFO_DEPTH or TIMEOUT");
   end
   state_t state;
   ioop_t op;
   word_t wd, head;
   logic [2:0] pia;
   logic txdone, under, over, full;
   logic [$clog2(FIFO_DEPTH):0] count;
   logic done, rd_op, wr_op, pop, push, flush, drop, load, tx_hs;
   logic [6:0] pi_next;
`ifdef IO_RESPONDER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] cnt;
`endif
   io_fifo #(.DEPTH(FIFO_DEPTH)) fifo (
      .clk(clk), .reset(reset), .flush(flush), .push(push), .pop(pop),
      .din(dev_in_data), .dout(head), .full(full), .count(count)
   );
   assign dev_in_ready = !full;
   always_comb begin
      done = count != '0;
      rd_op = op == BLKI || op == DATAI;
      wr_op = op == BLKO || op == DATAO;
      pop = rd_op && done && (state == EXEC || state == WAIT);
      flush = state == EXEC && op == CONO && wd[B_FLUSH];
      // a pop in the same cycle frees the slot, so a full FIFO still accepts
      push = dev_in_valid && (!full || pop) && !flush;
      drop = dev_in_valid && full && !pop;
      tx_hs = dev_out_valid && dev_out_ready;
      load = wr_op && (state == EXEC ? !dev_out_valid : state == WAIT && (!dev_out_valid || dev_out_ready));
      pi_next = (pia != 3'd0 && (done || txdone)) ? 7'd1 << (pia - 3'd1) : 7'd0;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         op <= CONI;
         wd <= '0;
         pia <= '0;
         dev_out_valid <= 1'b0;
         dev_out_data <= '0;
         txdone <= 1'b0;
         under <= 1'b0;
         over <= 1'b0;
         bus.io_ack <= 1'b0;
         bus.io_rdata <= '0;
         pi_req <= '0;
`ifdef IO_RESPONDER_TIMEOUT_EN
         cnt <= '0;
`endif
      end else begin
         bus.io_ack <= 1'b0;
         pi_req <= pi_next;
         if (tx_hs) begin
            dev_out_valid <= 1'b0;
            txdone <= 1'b1;
         end
         if (load) begin
            dev_out_data <= wd;
            dev_out_valid <= 1'b1;
            txdone <= 1'b0;
         end
         if (drop) over <= 1'b1;
         case (state)
            IDLE: if (bus.io_req && bus.io_dev == DEV_NUM) begin
               op <= bus.io_op;
               wd <= bus.io_wdata;
               state <= EXEC;
            end
            EXEC: begin
               state <= ACK;
`ifdef IO_RESPONDER_TIMEOUT_EN
               cnt <= '0;
`endif
               if (rd_op) begin
                  if (done) bus.io_rdata <= head;
`ifdef IO_RESPONDER_TIMEOUT_EN
                  else state <= WAIT;
`else
                  else begin
                     bus.io_rdata <= '0;
                     under <= 1'b1;
                  end
`endif
               end else if (wr_op) begin
`ifdef IO_RESPONDER_TIMEOUT_EN
                  if (dev_out_valid) state <= WAIT;
`else
                  if (dev_out_valid) over <= 1'b1;
`endif
               end else if (op == CONO) begin
                  pia <= wd[2:0];
                  if (wd[B_CLEAR]) begin
                     txdone <= 1'b0;
                     under <= 1'b0;
                     over <= 1'b0;
                  end
               end else bus.io_rdata <= cond_word(pia, done, dev_out_valid, txdone, under, over);
            end
            WAIT: begin
`ifdef IO_RESPONDER_TIMEOUT_EN
               cnt <= cnt + 1'b1;
               if (rd_op && done) begin
                  bus.io_rdata <= head;
                  state <= ACK;
               end else if (load) state <= ACK;
               else if (cnt == TW'(TIMEOUT - 1)) begin
                  state <= ACK;
                  if (rd_op) begin
                     bus.io_rdata <= '0;
                     under <= 1'b1;
                  end else over <= 1'b1;
               end
`else
               state <= ACK;
`endif
            end
            ACK: begin
               bus.io_ack <= 1'b1;
               state <= RELEASE;
            end
            RELEASE: if (!bus.io_req) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_io_responder.sv
// tb_io_responder: directed bench for io_responder against a transaction-level model
module tb_io_responder;
   import kv10_io_pkg::*;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic dev_in_valid = 1'b0, dev_out_ready = 1'b0, dev_in_ready, dev_out_valid;
   word_t dev_in_data = '0, dev_out_data;
   logic [6:0] pi_req;
   io_responder_if bus();
   io_responder dut (
      .clk(clk), .reset(reset), .bus(bus),
      .dev_in_valid(dev_in_valid), .dev_in_data(dev_in_data), .dev_in_ready(dev_in_ready),
      .dev_out_valid(dev_out_valid), .dev_out_data(dev_out_data), .dev_out_ready(dev_out_ready),
      .pi_req(pi_req)
   );
   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   bit settled = 1'b0;
   word_t mq[$];
   logic [2:0] m_pia = 3'd0;
   bit m_busy = 1'b0, m_txdone = 1'b0, m_under = 1'b0, m_over = 1'b0;
   word_t m_tx = '0;

   task automatic check(input string name, input word_t got, input word_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %o expected %o", name, got, exp);
      end
   endtask

   function automatic word_t m_cond();
      word_t w;
      w = 36'(m_pia);
      if (mq.size() != 0) w |= 36'd1 << (35 - 32);
      if (m_busy) w |= 36'd1 << (35 - 31);
      if (m_txdone) w |= 36'd1 << (35 - 30);
      if (m_under) w |= 36'd1 << (35 - 29);
      if (m_over) w |= 36'd1 << (35 - 28);
      return w;
   endfunction

   function automatic logic [6:0] m_pi();
      return (m_pia != 0 && (mq.size() != 0 || m_txdone)) ? 7'(1 << (m_pia - 1)) : 7'd0;
   endfunction

   initial forever begin
      @(posedge clk);
      #1;
      if (settled) begin
         check("in_ready", 36'(dev_in_ready), 36'(mq.size() < 4));
         check("out_valid", 36'(dev_out_valid), 36'(m_busy));
         if (m_busy) check("out_data", dev_out_data, m_tx);
         check("pi_req", 36'(pi_req), 36'(m_pi()));
         check("idle_ack", 36'(bus.io_ack), 36'd0);
      end
   end

   task automatic settle();
      repeat (3) @(negedge clk);
      settled = 1'b1;
      repeat (2) @(negedge clk);
      settled = 1'b0;
   endtask

   task automatic cpu(input ioop_t op, input logic [6:0] dev, input word_t wd, input int hold,
                      output word_t rd, output int lat);
      bit seen;
      seen = 1'b0;
      @(negedge clk);
      bus.io_req = 1'b1;
      bus.io_dev = dev;
      bus.io_op = op;
      bus.io_wdata = wd;
      @(posedge clk);
      lat = 0;
      rd = '0;
      while (!seen && lat < 40) begin
         @(negedge clk);
         if (bus.io_ack) begin
            seen = 1'b1;
            rd = bus.io_rdata;
         end else begin
            @(posedge clk);
            lat++;
         end
      end
      if (!seen) lat = -1;
      repeat (hold) begin
         @(negedge clk);
         check("ack_held", 36'(bus.io_ack), 36'd0);
      end
      bus.io_req = 1'b0;
      @(negedge clk);
      check("ack_once", 36'(bus.io_ack), 36'd0);
   endtask

   task automatic xact(input ioop_t op, input word_t wd, input int hold, output word_t rd);
      int lat;
      word_t exp;
      cpu(op, 7'o24, wd, hold, rd, lat);
      check("latency", 36'(lat), 36'd2);
      if (op == DATAI || op == BLKI) begin
         if (mq.size() != 0) exp = mq.pop_front();
         else begin
            exp = '0;
            m_under = 1'b1;
         end
         check("datai", rd, exp);
      end else if (op == DATAO || op == BLKO) begin
         if (m_busy) m_over = 1'b1;
         else begin
            m_tx = wd;
            m_busy = 1'b1;
            m_txdone = 1'b0;
         end
      end else if (op == CONO) begin
         m_pia = wd[2:0];
         if (wd[35 - 31]) begin
            m_txdone = 1'b0;
            m_under = 1'b0;
            m_over = 1'b0;
         end
         if (wd[35 - 32]) mq.delete();
      end else check("coni", rd, m_cond());
      settle();
   endtask

   task automatic push(input word_t w);
      @(negedge clk);
      dev_in_valid = 1'b1;
      dev_in_data = w;
      @(negedge clk);
      dev_in_valid = 1'b0;
      if (mq.size() < 4) mq.push_back(w);
      else m_over = 1'b1;
   endtask

   task automatic drain();
      @(negedge clk);
      dev_out_ready = 1'b1;
      @(negedge clk);
      dev_out_ready = 1'b0;
      if (m_busy) begin
         m_busy = 1'b0;
         m_txdone = 1'b1;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      word_t rd;
      bit any;
      bus.io_req = 1'b0;
      bus.io_dev = '0;
      bus.io_op = CONI;
      bus.io_wdata = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("rst_ack", 36'(bus.io_ack), 36'd0);
      check("rst_rdata", bus.io_rdata, 36'd0);
      check("rst_pi", 36'(pi_req), 36'd0);
      check("rst_out_valid", 36'(dev_out_valid), 36'd0);
      check("rst_in_ready", 36'(dev_in_ready), 36'd1);
      xact(CONI, '0, 0, rd);
      check("coni_reset", rd, 36'o0);
      xact(CONO, 36'o5, 0, rd);
      xact(CONI, '0, 0, rd);
      check("coni_pia", rd, 36'o5);
      push(36'o123456654321);
      settle();
      check("pi_done", 36'(pi_req), 36'(7'b0010000));
      xact(CONI, '0, 0, rd);
      check("coni_done", rd, 36'o15);
      xact(DATAI, '0, 0, rd);
      check("datai_word", rd, 36'o123456654321);
      push(36'o1);
      push(36'o2);
      settle();
      xact(DATAI, '0, 0, rd);
      check("datai_1", rd, 36'o1);
      xact(BLKI, '0, 0, rd);
      check("blki_2", rd, 36'o2);
      xact(CONI, '0, 0, rd);
      check("coni_empty", rd, 36'o5);
      check("pi_cleared", 36'(pi_req), 36'd0);
      xact(DATAO, 36'o777000000777, 0, rd);
      check("tx_valid", 36'(dev_out_valid), 36'd1);
      check("tx_data", dev_out_data, 36'o777000000777);
      xact(DATAO, 36'o111, 0, rd);
      xact(CONSZ, '0, 0, rd);
      check("coni_overrun", rd, 36'o225);
      xact(BLKO, 36'o222, 0, rd);
      check("tx_kept", dev_out_data, 36'o777000000777);
      repeat (10) @(negedge clk);
      drain();
      settle();
      check("pi_txdone", 36'(pi_req), 36'(7'b0010000));
      xact(CONSO, '0, 0, rd);
      check("coni_txdone", rd, 36'o245);
      xact(CONO, 36'o25, 0, rd);
      for (int i = 0; i < 5; i++) push(36'o10 + 36'(i));
      settle();
      check("full_ready", 36'(dev_in_ready), 36'd0);
      xact(CONI, '0, 0, rd);
      check("coni_full", rd, 36'o215);
      for (int i = 0; i < 4; i++) begin
         xact(DATAI, '0, 0, rd);
         check("datai_fifo", rd, 36'o10 + 36'(i));
      end
      xact(DATAI, '0, 0, rd);
      check("datai_underrun", rd, 36'o0);
      xact(CONI, '0, 0, rd);
      check("coni_under", rd, 36'o305);
      xact(CONO, 36'o20, 0, rd);
      xact(CONI, '0, 0, rd);
      check("coni_cleared", rd, 36'o0);
      push(36'o7);
      push(36'o10);
      xact(CONO, 36'o13, 0, rd);
      xact(CONI, '0, 0, rd);
      check("coni_flush", rd, 36'o3);
      @(negedge clk);
      bus.io_req = 1'b1;
      bus.io_dev = 7'o25;
      bus.io_op = CONI;
      any = 1'b0;
      repeat (50) begin
         @(negedge clk);
         if (bus.io_ack) any = 1'b1;
      end
      check("foreign_ack", 36'(any), 36'd0);
      bus.io_req = 1'b0;
      xact(CONI, '0, 5, rd);
      check("coni_hold", rd, 36'o3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
